ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-port data-RAM arbiter that shares the computer's data memory between the Hack CPU and a host/debug access port. The CPU owns the RAM by default. The host port is served when the CPU is not using memory, and is guaranteed a slot after a bounded wait by stalling the CPU for one cycle. The block sits between `cpu`, the RAM array (combinational read, write on clock edge) and an external loader/debugger.

## Interface
Parameters:
- `RAM_SIZE`, 32: number of RAM words; addresses ≥ RAM_SIZE are out of bounds.
- `MAX_WAIT`, 4: cycles a pending host request may be blocked by CPU traffic before a forced grant (range 1..255).
- `DATA_W`, 16: data width.
- `ADDR_W`, 16: address width on both requester ports.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU accesses memory this cycle (read or write).
- `cpu_addr` in ADDR_W: CPU address (addressM).
- `cpu_wdata` in DATA_W: CPU write data (outM).
- `cpu_we` in 1: CPU write (writeM).
- `cpu_rdata` out DATA_W: CPU read data (inM).
- `cpu_stall` out 1: CPU must hold state (clock-enable low) this cycle.
- `host_req_valid` in 1, `host_req_ready` out 1: host request handshake.
- `host_we` in 1, `host_addr` in ADDR_W, `host_wdata` in DATA_W: host request payload.
- `host_rsp_valid` out 1, `host_rsp_ready` in 1: host response handshake.
- `host_rdata` out DATA_W: registered read data (0 for writes).
- `mem_addr` out $clog2(RAM_SIZE), `mem_wdata` out DATA_W, `mem_we` out 1, `mem_rdata` in DATA_W: RAM side.
- `err_oob` out 1: sticky out-of-bounds flag.
- `stat_host_grants` out 16, `stat_stall_cycles` out 16: statistics (see Configuration).

## Operation
- States: IDLE (CPU owns RAM, host may be granted), RESP (host response pending).
- IDLE:
  - `host_req_ready = !cpu_req || (wait_cnt == MAX_WAIT)`.
  - Grant = `host_req_valid && host_req_ready`.
  - On grant:
    - RAM is driven by the host payload.
    - `cpu_stall = cpu_req`.
    - `host_rdata <= host_we ? 0 : rdata`.
    - `wait_cnt <= 0`.
    - Next state is RESP.
  - If `host_req_valid` is high but the host is not granted: `wait_cnt` increments.
  - Otherwise `wait_cnt` holds 0.
  - No grant: RAM is driven by the CPU; `mem_we = cpu_req && cpu_we`.
- RESP:
  - `host_rsp_valid = 1`; `host_req_ready = 0`; CPU owns RAM and is never stalled.
  - `host_rsp_ready` high → IDLE.
- Bounds check (either requester): if `addr ≥ RAM_SIZE`:
  - `mem_we` is forced 0.
  - Returned read data is 0.
  - `err_oob` is set; only reset clears it.
- `mem_addr` is the low $clog2(RAM_SIZE) bits of the selected address.

## Timing
- Reset values:
  - State IDLE, `wait_cnt` 0.
  - `host_rsp_valid` 0, `host_rdata` 0, `err_oob` 0, stats 0.
  - `cpu_stall` 0 until the first grant.
- CPU read latency: 0 cycles, combinational, `mem_rdata → cpu_rdata`.
- Host latency:
  - Response is valid the cycle after grant.
  - Minimum request spacing is 2 cycles (grant, RESP with `host_rsp_ready` = 1).
  - A new request is not accepted in the RESP-exit cycle.
- Worst-case host wait under continuous `cpu_req` is MAX_WAIT cycles; grant occurs in cycle MAX_WAIT+1.
- Each forced grant stalls the CPU for exactly 1 cycle. No two consecutive stall cycles occur.
- Simultaneous CPU write and host grant: the host write wins. The CPU write is repeated by the stalled CPU next cycle.
- Reset asserted in RESP: the response is dropped (`host_rsp_valid` → 0 next cycle) and the host must reissue.
- `host_req_valid` dropped before grant: `wait_cnt` returns to 0.

## Configuration
- `RAM_ARB_STATS_EN` defined:
  - `stat_host_grants` counts grants.
  - `stat_stall_cycles` counts cycles with `cpu_stall` = 1.
  - Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: both outputs are tied to 0 and no counter logic is generated. The port list is unchanged.

## Structure
- Package `ram_arb_pkg`:
  - State enum `arb_state_t` {IDLE, RESP}.
  - `DATA_W`/`ADDR_W` defaults.
  - Saturating-counter width constant.
- Sub-module `ram_arb_stats`: the two saturating counters, instantiated only under `RAM_ARB_STATS_EN`.

## Test plan
- CPU idle (`cpu_req` = 0): host writes 0x1234 to addr 5 → grant in the same cycle, `mem_we` = 1, `host_rsp_valid` next cycle. A following host read of addr 5 returns `host_rdata` = 0x1234.
- `cpu_req` held 1 with MAX_WAIT = 4, host read pending from cycle 0 → `host_req_ready` low for cycles 0–3, grant in cycle 4 with `cpu_stall` = 1 for exactly that cycle, `stat_stall_cycles` = 1.
- CPU write 7 to addr 3 in the same cycle as a forced host write 9 to addr 3 → RAM holds 9 after the grant cycle, the CPU stalls, and the CPU's repeated write leaves 7 on the next cycle.
- Host read of addr 40 (RAM_SIZE = 32) → `host_rdata` = 0, no RAM write, `err_oob` = 1 and still 1 after 10 idle cycles; reset clears it.
- Host holds `host_rsp_ready` = 0 for 3 cycles → `host_rsp_valid` and `host_rdata` stable, `host_req_ready` = 0, no stalls. Reset asserted during RESP → `host_rsp_valid` = 0 next cycle.
- Build without `RAM_ARB_STATS_EN`: after 5 grants, both stat outputs are 0. With the macro: `stat_host_grants` = 5.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the Hack CPU and the host port.
package ram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/ram_arb_stats.sv
// Saturating host-grant and CPU-stall counters; only instantiated when RAM_ARB_STATS_EN is defined.
module ram_arb_stats
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              grant,
  input  logic              stall,
  output logic [STAT_W-1:0] host_grants,
  output logic [STAT_W-1:0] stall_cycles
);

  always_ff @(posedge clk) begin
    if (reset) begin
      host_grants  <= '0;
      stall_cycles <= '0;
    end else begin
      if (grant && (host_grants != '1)) host_grants <= host_grants + 1'b1;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data-RAM arbiter: CPU owns the RAM, host gets idle slots or a forced one-cycle stall.
// Optional statistics counters are built when RAM_ARB_STATS_EN is defined.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_SIZE = 32,
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  localparam int MEM_AW  = $clog2(RAM_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_oob,
  output logic [15:0]       stat_host_grants,
  output logic [15:0]       stat_stall_cycles
);

  localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_SIZE);
  localparam logic [7:0]        WAIT_MAX  = 8'(MAX_WAIT);

  // Handshakes: a host request transfers in a cycle where host_req_valid && host_req_ready;
  // a response transfers where host_rsp_valid && host_rsp_ready. Payloads must hold while valid is high.
  arb_state_t  state, state_next;
  logic [7:0]  wait_cnt;
  logic        grant;
  logic        cpu_oob, host_oob;

  assign cpu_oob  = (cpu_addr >= RAM_LIMIT);
  assign host_oob = (host_addr >= RAM_LIMIT);

  always_comb begin
    state_next     = state;
    host_req_ready = 1'b0;
    host_rsp_valid = 1'b0;
    grant          = 1'b0;
    cpu_stall      = 1'b0;
    case (state)
      IDLE: begin
        host_req_ready = !cpu_req || (wait_cnt == WAIT_MAX);
        grant          = host_req_valid && host_req_ready;
        cpu_stall      = grant && cpu_req;
        if (grant) state_next = RESP;
      end
      RESP: begin
        host_rsp_valid = 1'b1;
        if (host_rsp_ready) state_next = IDLE;
      end
    endcase
  end

  // The RAM follows the host only in the grant cycle; otherwise the CPU drives it.
  always_comb begin
    mem_addr  = cpu_addr[MEM_AW-1:0];
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req && cpu_we && !cpu_oob;
    if (grant) begin
      mem_addr  = host_addr[MEM_AW-1:0];
      mem_wdata = host_wdata;
      mem_we    = host_we && !host_oob;
    end
    cpu_rdata = cpu_oob ? '0 : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      host_rdata <= '0;
      err_oob    <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        wait_cnt   <= '0;
        host_rdata <= (host_we || host_oob) ? '0 : mem_rdata;
      end else if ((state == IDLE) && host_req_valid) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      // A stalled CPU access is repeated next cycle, so it is judged then.
      if ((grant && host_oob) || (cpu_req && !cpu_stall && cpu_oob)) err_oob <= 1'b1;
    end
  end

`ifdef RAM_ARB_STATS_EN
  ram_arb_stats u_stats (
    .clk          (clk),
    .reset        (reset),
    .grant        (grant),
    .stall        (cpu_stall),
    .host_grants  (stat_host_grants),
    .stall_cycles (stat_stall_cycles)
  );
`else
  assign stat_host_grants  = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32-word RAM (combinational read, clocked write).
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_we;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [15:0] host_rdata;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        err_oob;
  logic [15:0] stat_host_grants;
  logic [15:0] stat_stall_cycles;

  logic [15:0] ram [32];

  int checks = 0;
  int errors = 0;

`ifdef RAM_ARB_STATS_EN
  localparam logic [15:0] EXP_STALL1 = 16'd1;
  localparam logic [15:0] EXP_STALL2 = 16'd2;
  localparam logic [15:0] EXP_GRANT5 = 16'd5;
`else
  localparam logic [15:0] EXP_STALL1 = 16'd0;
  localparam logic [15:0] EXP_STALL2 = 16'd0;
  localparam logic [15:0] EXP_GRANT5 = 16'd0;
`endif

  ram_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_req           (cpu_req),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_we            (cpu_we),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .host_req_valid    (host_req_valid),
    .host_req_ready    (host_req_ready),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_rsp_valid    (host_rsp_valid),
    .host_rsp_ready    (host_rsp_ready),
    .host_rdata        (host_rdata),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
    .mem_rdata         (mem_rdata),
    .err_oob           (err_oob),
    .stat_host_grants  (stat_host_grants),
    .stat_stall_cycles (stat_stall_cycles)
  );

  // Clock and RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_drive(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    host_req_valid = 1'b1;
    host_we        = we;
    host_addr      = addr;
    host_wdata     = wdata;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
    host_req_valid = 1'b0;
    host_we        = 1'b0;
    host_addr      = 16'h0;
    host_wdata     = 16'h0;
    host_rsp_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_rsp_valid", host_rsp_valid, 1'b0);
    check("rst_rdata", host_rdata, 16'h0);
    check("rst_err", err_oob, 1'b0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_ready", host_req_ready, 1'b1);
    check("rst_stat_g", stat_host_grants, 16'h0);
    check("rst_stat_s", stat_stall_cycles, 16'h0);

    // CPU idle: host write 0x1234 to addr 5, granted immediately
    host_drive(1'b1, 16'd5, 16'h1234);
    #1;
    check("t1_ready", host_req_ready, 1'b1);
    check("t1_mem_we", mem_we, 1'b1);
    check("t1_mem_addr", mem_addr, 5'd5);
    check("t1_mem_wdata", mem_wdata, 16'h1234);
    check("t1_stall", cpu_stall, 1'b0);
    tick();
    // In RESP: queue a read of addr 5 and complete the response in the same cycle
    host_drive(1'b0, 16'd5, 16'h0);
    host_rsp_ready = 1'b1;
    #1;
    check("t1_rsp_valid", host_rsp_valid, 1'b1);
    check("t1_wr_rdata", host_rdata, 16'h0);
    check("t1_exit_ready", host_req_ready, 1'b0);
    check("t1_ram5", ram[5], 16'h1234);
    tick();
    host_rsp_ready = 1'b0;
    #1;
    check("t1_rd_ready", host_req_ready, 1'b1);
    check("t1_rd_rsp_idle", host_rsp_valid, 1'b0);
    tick();
    host_req_valid = 1'b0;
    #1;
    check("t1_rd_rdata", host_rdata, 16'h1234);
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;

    // Continuous CPU reads: host read blocked 4 cycles, forced grant on the 5th
    cpu_drive(1'b1, 1'b0, 16'd1, 16'h0);
    host_drive(1'b0, 16'd5, 16'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t2_blocked", host_req_ready, 1'b0);
      check("t2_no_stall", cpu_stall, 1'b0);
      tick();
    end
    #1;
    check("t2_ready", host_req_ready, 1'b1);
    check("t2_stall", cpu_stall, 1'b1);
    check("t2_mem_addr", mem_addr, 5'd5);
    tick();
    host_req_valid = 1'b0;
    #1;
    check("t2_stall_once", cpu_stall, 1'b0);
    check("t2_rsp_valid", host_rsp_valid, 1'b1);
    check("t2_rdata", host_rdata, 16'h1234);
    check("t2_stat_s", stat_stall_cycles, EXP_STALL1);
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    cpu_req = 1'b0;

    // CPU write 7 vs forced host write 9 to addr 3
    cpu_drive(1'b1, 1'b1, 16'd3, 16'd7);
    host_drive(1'b1, 16'd3, 16'd9);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t3_blocked", host_req_ready, 1'b0);
      tick();
    end
    #1;
    check("t3_stall", cpu_stall, 1'b1);
    check("t3_mem_we", mem_we, 1'b1);
    check("t3_mem_wdata", mem_wdata, 16'd9);
    tick();
    host_req_valid = 1'b0;
    #1;
    check("t3_ram_host", ram[3], 16'd9);
    check("t3_no_stall", cpu_stall, 1'b0);
    check("t3_cpu_wdata", mem_wdata, 16'd7);
    tick();
    #1;
    check("t3_ram_cpu", ram[3], 16'd7);
    cpu_drive(1'b0, 1'b0, 16'd0, 16'd0);
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;

    // Host read out of bounds
    host_drive(1'b0, 16'd40, 16'h0);
    #1;
    check("t4_ready", host_req_ready, 1'b1);
    check("t4_mem_we", mem_we, 1'b0);
    tick();
    host_req_valid = 1'b0;
    #1;
    check("t4_rsp_valid", host_rsp_valid, 1'b1);
    check("t4_rdata", host_rdata, 16'h0);
    check("t4_err", err_oob, 1'b1);
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    repeat (10) tick();
    #1;
    check("t4_err_sticky", err_oob, 1'b1);
    check("t4_stat_g", stat_host_grants, EXP_GRANT5);
    check("t4_stat_s", stat_stall_cycles, EXP_STALL2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t4_err_clr", err_oob, 1'b0);
    check("t4_stat_g_clr", stat_host_grants, 16'h0);

    // CPU write out of bounds: no RAM write, flag set
    cpu_drive(1'b1, 1'b1, 16'd40, 16'hBEEF);
    #1;
    check("t4_cpu_mem_we", mem_we, 1'b0);
    tick();
    cpu_drive(1'b0, 1'b0, 16'd0, 16'd0);
    #1;
    check("t4_cpu_err", err_oob, 1'b1);
    check("t4_ram8", ram[8], 16'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Response back-pressure, then reset during RESP
    host_drive(1'b0, 16'd5, 16'h0);
    tick();
    host_req_valid = 1'b0;
    cpu_drive(1'b1, 1'b0, 16'd3, 16'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t5_rsp_hold", host_rsp_valid, 1'b1);
      check("t5_rdata_hold", host_rdata, 16'h1234);
      check("t5_ready_low", host_req_ready, 1'b0);
      check("t5_no_stall", cpu_stall, 1'b0);
      check("t5_cpu_rdata", cpu_rdata, 16'd7);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t5_rsp_dropped", host_rsp_valid, 1'b0);

    // Dropping the request before grant restarts the wait
    host_drive(1'b0, 16'd5, 16'h0);
    repeat (2) tick();
    host_req_valid = 1'b0;
    tick();
    host_req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t6_blocked", host_req_ready, 1'b0);
      tick();
    end
    #1;
    check("t6_ready", host_req_ready, 1'b1);
    tick();
    host_req_valid = 1'b0;
    cpu_req = 1'b0;
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
